// File: rtl/qduc.sv
// qduc: quadrature digital up-converter.
// Low-rate I/Q words enter through a one-deep holding register. A CIC interpolator
// raises them by 2^RATE_LOG2 to the clk rate, and a quarter-wave LUT NCO mixes them
// to one real sample per clk.
// Optional feature: define QDUC_UNDERRUN_CNT_EN to add the saturating underrun_cnt port.
module qduc #(
  parameter int ISZ        = 16,
  parameter int OSZ        = 16,
  parameter int FSZ        = 31,
  parameter int NUM_STAGES = 3,
  parameter int RATE_LOG2  = 7,
  parameter int LUT_AW     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [ISZ-1:0] in_i,
  input  logic signed [ISZ-1:0] in_q,
  input  logic [FSZ-1:0]        lo_freq,
  input  logic                  lo_dir,
  input  logic                  iq_swap,
  output logic signed [OSZ-1:0] out
`ifdef QDUC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int CICW  = ISZ + NUM_STAGES * RATE_LOG2;
  localparam int GSH   = (NUM_STAGES - 1) * RATE_LOG2;
  localparam int NCOW  = 17;
  localparam int PW    = ISZ + NCOW;
  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic signed [PW-1:0] OUT_MAX = PW'((2 ** (OSZ - 1)) - 1);
  localparam logic signed [PW-1:0] OUT_MIN = ~OUT_MAX;

  // Quarter-wave entry k: round(32767*sin(pi/2*(k+0.5)/LUT_N)); half-step offset
  // keeps every entry nonzero and makes the mirrored address exactly symmetric.
  function automatic logic [15:0] lut_val(input int k);
    real ang;
    real v;
    ang = 3.141592653589793 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    v   = 32767.0 * $sin(ang);
    return 16'($rtoi(v + 0.5));
  endfunction

  // ---------------- rate counter ----------------
  logic [RATE_LOG2-1:0] rate_cnt_q;
  logic                 strobe;

  assign strobe = &rate_cnt_q;

  // Free-running interpolation phase counter.
  always_ff @(posedge clk) begin
    if (reset) rate_cnt_q <= '0;
    else       rate_cnt_q <= rate_cnt_q + 1'b1;
  end

  // ---------------- input holding register ----------------
  // Handshake: a word transfers on every clk where in_valid && in_ready; in_ready is
  // a pure function of the holding register (never of in_valid) and stays low until
  // a strobe consumes the held word. A strobe on an empty register feeds zero.
  logic                  hold_full_q;
  logic signed [ISZ-1:0] hold_i_q, hold_q_q;
  logic                  xfer;

  assign in_ready = !hold_full_q;
  assign xfer     = in_valid && in_ready;

  // Capture on transfer, release on strobe (a same-cycle capture waits for the next strobe).
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
    end else begin
      if (strobe) hold_full_q <= 1'b0;
      if (xfer) begin
        hold_full_q <= 1'b1;
        hold_i_q    <= in_i;
        hold_q_q    <= in_q;
      end
    end
  end

  // ---------------- CIC combs (strobe rate) ----------------
  // Channel index 0 carries I, 1 carries Q.
  logic signed [CICW-1:0] comb_d     [2][NUM_STAGES+1];
  logic signed [CICW-1:0] comb_dly_q [2][NUM_STAGES];
  logic signed [CICW-1:0] comb_out_q [2];

  // Optional swap, sign extension and the full combinational comb chain.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s <= NUM_STAGES; s++) comb_d[c][s] = '0;
    end
    if (hold_full_q) begin
      comb_d[0][0] = CICW'(iq_swap ? hold_q_q : hold_i_q);
      comb_d[1][0] = CICW'(iq_swap ? hold_i_q : hold_q_q);
    end
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        comb_d[c][s+1] = comb_d[c][s] - comb_dly_q[c][s];
      end
    end
  end

  // Comb delays advance on strobe; comb output is the zero-stuffed upsampled stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        comb_out_q[c] <= '0;
        for (int s = 0; s < NUM_STAGES; s++) comb_dly_q[c][s] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        comb_out_q[c] <= strobe ? comb_d[c][NUM_STAGES] : '0;
        if (strobe) begin
          for (int s = 0; s < NUM_STAGES; s++) comb_dly_q[c][s] <= comb_d[c][s];
        end
      end
    end
  end

  // ---------------- CIC integrators (clk rate) ----------------
  logic signed [CICW-1:0] integ_q [2][NUM_STAGES];
  logic signed [ISZ-1:0]  trim_q  [2];

  // Cascaded wrap-around integrators, then drop the 2^GSH DC gain by truncation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        trim_q[c] <= '0;
        for (int s = 0; s < NUM_STAGES; s++) integ_q[c][s] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        integ_q[c][0] <= integ_q[c][0] + comb_out_q[c];
        for (int s = 1; s < NUM_STAGES; s++) integ_q[c][s] <= integ_q[c][s] + integ_q[c][s-1];
        trim_q[c] <= integ_q[c][NUM_STAGES-1][ISZ+GSH-1:GSH];
      end
    end
  end

  // ---------------- NCO ----------------
  logic [FSZ-1:0]         phase_q, phase_d;
  logic [1:0]             quad;
  logic [LUT_AW-1:0]      lut_addr;
  logic [15:0]            lut [LUT_N];
  logic signed [NCOW-1:0] lut_fwd, lut_rev, nco_sin, nco_cos;

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [15:0] LUT_VAL = lut_val(k);
    assign lut[k] = LUT_VAL;
  end

  assign phase_d  = lo_dir ? (phase_q - lo_freq) : (phase_q + lo_freq);
  assign quad     = phase_q[FSZ-1 -: 2];
  assign lut_addr = phase_q[FSZ-3 -: LUT_AW];
  assign lut_fwd  = {1'b0, lut[lut_addr]};
  assign lut_rev  = {1'b0, lut[~lut_addr]};

  // Phase accumulator; its current value lines up with trim_q in the mixer.
  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  // Rebuild full-wave sin/cos from the quarter table by mirroring and negation.
  always_comb begin
    nco_sin = '0;
    nco_cos = '0;
    case (quad)
      2'd0:    begin nco_sin = lut_fwd;  nco_cos = lut_rev;  end
      2'd1:    begin nco_sin = lut_rev;  nco_cos = -lut_fwd; end
      2'd2:    begin nco_sin = -lut_fwd; nco_cos = -lut_rev; end
      default: begin nco_sin = -lut_rev; nco_cos = lut_fwd;  end
    endcase
  end

  // ---------------- mixer and output ----------------
  logic signed [PW-1:0]  prod_d, prod_q, prod_sh;
  logic signed [OSZ-1:0] out_d, out_q;

  assign prod_d = PW'(trim_q[0]) * PW'(nco_cos) - PW'(trim_q[1]) * PW'(nco_sin);

  // Scale back by 2^15 (floor) and clamp instead of wrapping.
  always_comb begin
    prod_sh = prod_q >>> (NCOW - 2);
    if (prod_sh > OUT_MAX)      out_d = OUT_MAX[OSZ-1:0];
    else if (prod_sh < OUT_MIN) out_d = OUT_MIN[OSZ-1:0];
    else                        out_d = prod_sh[OSZ-1:0];
  end

  // Product and output pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef QDUC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Count strobes that found the holding register empty, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) underrun_cnt_q <= '0;
    else if (strobe && !hold_full_q && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
